// File: rtl/rect_draw_arbiter.sv
// Round-robin arbiter that fills solid-colour rectangles through the LT24Display
// pixel write port, one clipped pixel per accepted write, row by row.
module rect_draw_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    reqX0,
  input  logic [9*NUM_REQ-1:0]    reqY0,
  input  logic [8*NUM_REQ-1:0]    reqW,
  input  logic [9*NUM_REQ-1:0]    reqH,
  input  logic [16*NUM_REQ-1:0]   reqColour,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [7:0]              xAddr,
  output logic [8:0]              yAddr,
  output logic [15:0]             pixelData,
  output logic                    pixelWrite,
  input  logic                    pixelReady,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                 REC_W   = 50;
  localparam logic [9:0]         X_MAX   = 10'(WIDTH - 1);
  localparam logic [9:0]         Y_MAX   = 10'(HEIGHT - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
  localparam logic [NUM_REQ-1:0] PTR_RST = NUM_REQ'(1) << (NUM_REQ - 1);

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_ptr_oh, w_ptr_nxt;
  logic [NUM_REQ-1:0]   r_win_oh, w_win_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]   r_done, w_done_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [7:0]           r_x, w_x_nxt;
  logic [8:0]           r_y, w_y_nxt;
  logic [7:0]           r_x0, w_x0_nxt;
  logic [7:0]           r_x1, w_x1_nxt;
  logic [8:0]           r_y1, w_y1_nxt;
  logic [15:0]          r_data, w_data_nxt;
  logic                 r_pw, w_pw_nxt;

  // Round-robin pick: lowest request strictly above the pointer, else lowest overall.
  logic [NUM_REQ-1:0]   w_upper, w_sel, w_pick_oh;
  assign w_upper   = req & ~((r_ptr_oh << 1) - ONE);
  assign w_sel     = (|w_upper) ? w_upper : req;
  assign w_pick_oh = w_sel & (~w_sel + ONE);

  logic [NUM_REQ:0][REC_W-1:0] w_rec_acc;
  logic [7:0]  w_x0, w_w;
  logic [8:0]  w_y0, w_h;
  logic [15:0] w_col;

  assign w_rec_acc[0] = '0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
    assign w_rec_acc[gi+1] = w_rec_acc[gi] | ({REC_W{w_pick_oh[gi]}} &
                             {reqX0[8*gi +: 8], reqY0[9*gi +: 9], reqW[8*gi +: 8],
                              reqH[9*gi +: 9], reqColour[16*gi +: 16]});
  end
  assign {w_x0, w_y0, w_w, w_h, w_col} = w_rec_acc[NUM_REQ];

  logic [9:0] w_x_end, w_y_end;
  logic [7:0] w_x1;
  logic [8:0] w_y1;
  logic       w_empty;

  assign w_x_end = {2'b00, w_x0} + {2'b00, w_w} - 10'd1;
  assign w_y_end = {1'b0, w_y0} + {1'b0, w_h} - 10'd1;
  assign w_x1    = (w_x_end > X_MAX) ? X_MAX[7:0] : w_x_end[7:0];
  assign w_y1    = (w_y_end > Y_MAX) ? Y_MAX[8:0] : w_y_end[8:0];
  assign w_empty = (w_w == 8'd0) || (w_h == 9'd0) ||
                   ({2'b00, w_x0} > X_MAX) || ({1'b0, w_y0} > Y_MAX);

  // pixelWrite/pixelReady: a pixel transfers on every cycle where both are high;
  // while pixelWrite is high and pixelReady low, xAddr/yAddr/pixelData stay put.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr_oh;
    w_win_nxt   = r_win_oh;
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    w_busy_nxt  = r_busy;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_x0_nxt    = r_x0;
    w_x1_nxt    = r_x1;
    w_y1_nxt    = r_y1;
    w_data_nxt  = r_data;
    w_pw_nxt    = r_pw;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_ptr_nxt   = w_pick_oh;
          w_win_nxt   = w_pick_oh;
          w_grant_nxt = w_pick_oh;
          w_busy_nxt  = 1'b1;
          w_x_nxt     = w_x0;
          w_y_nxt     = w_y0;
          w_x0_nxt    = w_x0;
          w_x1_nxt    = w_x1;
          w_y1_nxt    = w_y1;
          w_data_nxt  = w_col;
          w_pw_nxt    = ~w_empty;
          w_state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        // An empty rect spends its grant cycle here without writing.
        if (!r_pw) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_win_oh;
        end else if (pixelReady) begin
          if (r_x == r_x1) begin
            if (r_y == r_y1) begin
              w_pw_nxt    = 1'b0;
              w_state_nxt = S_DONE;
              w_done_nxt  = r_win_oh;
            end else begin
              w_x_nxt = r_x0;
              w_y_nxt = r_y + 9'd1;
            end
          end else begin
            w_x_nxt = r_x + 8'd1;
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ptr_oh <= PTR_RST;
      r_win_oh <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_x0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_data   <= '0;
      r_pw     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr_oh <= w_ptr_nxt;
      r_win_oh <= w_win_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_x0     <= w_x0_nxt;
      r_x1     <= w_x1_nxt;
      r_y1     <= w_y1_nxt;
      r_data   <= w_data_nxt;
      r_pw     <= w_pw_nxt;
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign busy        = r_busy;
  assign xAddr       = r_x;
  assign yAddr       = r_y;
  assign pixelData   = r_data;
  assign pixelWrite  = r_pw;
  assign o_dbg_state = r_state;

endmodule
